// File: rtl/ghost_collision.sv
// Ghost/PacMan overlap detector with the life, death and respawn sequence; one clock = one video frame.
// Optional post-respawn invulnerability is compiled in with `define GHOST_COLLISION_INVULN_EN.
module ghost_collision #(
  parameter int LIVES_INIT     = 3,
  parameter int DEATH_FRAMES   = 60,
  parameter int RESPAWN_FRAMES = 120,
  parameter int SLACK          = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       game_active,
  input  logic       powered,
  input  logic [9:0] pacX,
  input  logic [9:0] pacY,
  input  logic [9:0] pacS,
  input  logic [9:0] ghostX,
  input  logic [9:0] ghostY,
  input  logic [9:0] ghostS,
  output logic       hit,
  output logic       eaten,
  output logic       freeze,
  output logic       invuln,
  output logic [1:0] lives,
  output logic       game_over
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    DYING = 2'd1,
    OVER  = 2'd2
`ifdef GHOST_COLLISION_INVULN_EN
    , RESPAWN = 2'd3
`endif
  } state_t;

  localparam logic [10:0] SLACK_W    = 11'(SLACK);
  localparam logic [7:0]  DEATH_LOAD = 8'(DEATH_FRAMES - 1);
  localparam logic [1:0]  LIVES_W    = 2'(LIVES_INIT);

  generate
    if (LIVES_INIT < 1 || LIVES_INIT > 3 || DEATH_FRAMES < 1 || DEATH_FRAMES > 255 ||
        RESPAWN_FRAMES < 1 || RESPAWN_FRAMES > 255) begin : g_param_check
      $error("ghost_collision: parameter outside legal range");
    end
  endgenerate

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  lives_q;
  logic        ov_q;
  logic        armed_q;
  logic        hit_q;
  logic        eaten_q;
  logic        freeze_q;
  logic        invuln_q;
  logic        over_q;

  logic [10:0] dx_d;
  logic [10:0] dy_d;
  logic [10:0] size_sum_d;
  logic        ov_d;
  logic        hit_fire_d;
  logic        eat_fire_d;

  // size_sum is treated as signed: bit 10 set means the tolerance swallowed the sizes.
  always_comb begin
    dx_d       = (pacX >= ghostX) ? ({1'b0, pacX} - {1'b0, ghostX}) : ({1'b0, ghostX} - {1'b0, pacX});
    dy_d       = (pacY >= ghostY) ? ({1'b0, pacY} - {1'b0, ghostY}) : ({1'b0, ghostY} - {1'b0, pacY});
    size_sum_d = {1'b0, pacS} + {1'b0, ghostS} - SLACK_W;
    ov_d       = !size_sum_d[10] && (size_sum_d != 11'd0) && (dx_d < size_sum_d) && (dy_d < size_sum_d);
  end

  assign hit_fire_d = (state_q == PLAY) && game_active && ov_q && !powered;
  assign eat_fire_d = (state_q == PLAY) && game_active && ov_q && powered && armed_q;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q  <= PLAY;
      cnt_q    <= 8'd0;
      lives_q  <= LIVES_W;
      ov_q     <= 1'b0;
      armed_q  <= 1'b1;
      hit_q    <= 1'b0;
      eaten_q  <= 1'b0;
      freeze_q <= 1'b0;
      invuln_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      hit_q   <= 1'b0;
      eaten_q <= 1'b0;
      if (game_active) begin
        ov_q <= ov_d;
      end
      // Disarm on an eat so a held contact cannot be eaten twice.
      if (eat_fire_d) begin
        armed_q <= 1'b0;
      end else if (!ov_q) begin
        armed_q <= 1'b1;
      end

      case (state_q)
        PLAY: begin
          if (hit_fire_d) begin
            hit_q    <= 1'b1;
            freeze_q <= 1'b1;
            lives_q  <= (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            cnt_q    <= DEATH_LOAD;
            state_q  <= DYING;
          end else if (eat_fire_d) begin
            eaten_q <= 1'b1;
          end
        end
        DYING: begin
          if (game_active) begin
            if (cnt_q == 8'd0) begin
              freeze_q <= 1'b0;
              if (lives_q == 2'd0) begin
                over_q  <= 1'b1;
                state_q <= OVER;
              end else begin
`ifdef GHOST_COLLISION_INVULN_EN
                invuln_q <= 1'b1;
                cnt_q    <= 8'(RESPAWN_FRAMES - 1);
                state_q  <= RESPAWN;
`else
                state_q  <= PLAY;
`endif
              end
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
`ifdef GHOST_COLLISION_INVULN_EN
        RESPAWN: begin
          if (game_active) begin
            if (cnt_q == 8'd0) begin
              invuln_q <= 1'b0;
              state_q  <= PLAY;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
`endif
        OVER: begin
          over_q <= 1'b1;
        end
        default: begin
          state_q <= PLAY;
        end
      endcase
    end
  end

  assign hit       = hit_q;
  assign eaten     = eaten_q;
  assign freeze    = freeze_q;
  assign invuln    = invuln_q;
  assign lives     = lives_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_ghost_collision.sv
// Directed bench for ghost_collision: contact death, overlap boundary, pause, power eat, game over, reset.
module tb_ghost_collision;

`ifdef GHOST_COLLISION_INVULN_EN
  localparam int RESP_EXP = 120;
`else
  localparam int RESP_EXP = 0;
`endif

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       game_active = 1'b0;
  logic       powered = 1'b0;
  logic [9:0] pacX = 10'd100, pacY = 10'd100, pacS = 10'd10;
  logic [9:0] ghostX = 10'd300, ghostY = 10'd300, ghostS = 10'd10;
  logic       hit, eaten, freeze, invuln, game_over;
  logic [1:0] lives;

  int vectors = 0;
  int miscompares = 0;

  always #5 frame_clk = ~frame_clk;

  ghost_collision dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .game_active(game_active),
    .powered    (powered),
    .pacX       (pacX),
    .pacY       (pacY),
    .pacS       (pacS),
    .ghostX     (ghostX),
    .ghostY     (ghostY),
    .ghostS     (ghostS),
    .hit        (hit),
    .eaten      (eaten),
    .freeze     (freeze),
    .invuln     (invuln),
    .lives      (lives),
    .game_over  (game_over)
  );

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic place_ghost(input int x, input int y);
    ghostX = 10'(x);
    ghostY = 10'(y);
  endtask

  // Counts consecutive cycles (starting with the current one) where freeze (sel=0) or invuln (sel=1) is high.
  task automatic count_high(input int sel, output int n);
    n = 0;
    while (n < 1000 && ((sel == 0) ? freeze : invuln)) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    int e_sum;
    int h_sum;
    int go_sum;

    game_active = 1'b1;
    step();
    step();
    chk("rst_lives", lives, 3);
    chk("rst_hit", hit, 0);
    chk("rst_eaten", eaten, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_invuln", invuln, 0);
    chk("rst_game_over", game_over, 0);
    Reset = 1'b0;
    step();

    // dx = 16 equals the size sum: no overlap
    place_ghost(116, 100);
    h_sum = 0;
    repeat (4) begin
      step();
      h_sum += int'(hit) + int'(freeze);
    end
    chk("dx16_no_hit", h_sum, 0);

    // dx = 15: contact death, hit two edges after stimulus
    place_ghost(115, 100);
    step();
    chk("dx15_hit_lat1", hit, 0);
    step();
    chk("dx15_hit", hit, 1);
    chk("dx15_freeze", freeze, 1);
    chk("dx15_lives", lives, 2);
    chk("dx15_eaten", eaten, 0);
    place_ghost(300, 300);
    step();
    chk("hit_pulse_end", hit, 0);
    count_high(0, n);
    chk("death1_freeze_len", n + 1, 60);
    count_high(1, n);
    chk("respawn1_len", n, RESP_EXP);
    chk("play1_freeze", freeze, 0);
    chk("play1_invuln", invuln, 0);
    chk("play1_game_over", game_over, 0);
    chk("play1_lives", lives, 2);

    // Spec contact at (105,100); pause 20 frames mid-DYING
    place_ghost(105, 100);
    step();
    step();
    chk("death2_hit", hit, 1);
    chk("death2_lives", lives, 1);
    place_ghost(300, 300);
    n = 0;
    while (n < 1000 && freeze) begin
      n++;
      if (n == 10) game_active = 1'b0;
      if (n == 30) game_active = 1'b1;
      step();
    end
    chk("pause_freeze_len", n, 80);
    count_high(1, n);
    chk("respawn2_len", n, RESP_EXP);

    // Power eat: one pulse across a held contact
    powered = 1'b1;
    place_ghost(105, 100);
    step();
    chk("eat_lat1", eaten, 0);
    step();
    chk("eat_pulse", eaten, 1);
    e_sum = 0;
    h_sum = 0;
    repeat (9) begin
      step();
      e_sum += int'(eaten);
      h_sum += int'(hit) + int'(freeze);
    end
    chk("eat_no_repeat", e_sum, 0);
    chk("eat_no_hit", h_sum, 0);
    chk("eat_lives", lives, 1);

    // Separate one frame, re-contact: second eat
    place_ghost(300, 300);
    step();
    place_ghost(105, 100);
    step();
    chk("reeat_lat1", eaten, 0);
    step();
    chk("reeat_pulse", eaten, 1);
    chk("reeat_hit", hit, 0);

    // powered drops as ov_r rises: death, last life
    place_ghost(300, 300);
    repeat (3) step();
    place_ghost(105, 100);
    step();
    powered = 1'b0;
    step();
    chk("drop_hit", hit, 1);
    chk("drop_eaten", eaten, 0);
    chk("drop_lives", lives, 0);
    step();
    count_high(0, n);
    chk("death3_freeze_len", n + 1, 60);
    chk("over_game_over", game_over, 1);
    chk("over_invuln", invuln, 0);

    // Game over holds under contact
    go_sum = 0;
    h_sum = 0;
    e_sum = 0;
    repeat (20) begin
      powered = ~powered;
      step();
      go_sum += int'(game_over);
      h_sum += int'(hit) + int'(freeze);
      e_sum += int'(eaten);
    end
    chk("over_hold", go_sum, 20);
    chk("over_no_hit", h_sum, 0);
    chk("over_no_eat", e_sum, 0);
    chk("over_lives", lives, 0);

    // Reset out of OVER, then reset mid-DYING
    Reset = 1'b1;
    powered = 1'b0;
    place_ghost(300, 300);
    step();
    Reset = 1'b0;
    chk("rst2_lives", lives, 3);
    chk("rst2_game_over", game_over, 0);
    place_ghost(105, 100);
    step();
    step();
    chk("death4_hit", hit, 1);
    chk("death4_lives", lives, 2);
    repeat (5) step();
    chk("death4_freeze", freeze, 1);
    Reset = 1'b1;
    step();
    chk("middie_rst_freeze", freeze, 0);
    chk("middie_rst_lives", lives, 3);
    chk("middie_rst_hit", hit, 0);
    chk("middie_rst_eaten", eaten, 0);
    chk("middie_rst_invuln", invuln, 0);
    chk("middie_rst_game_over", game_over, 0);
    Reset = 1'b0;
    place_ghost(300, 300);
    step();
    step();
    chk("post_rst_play", freeze, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
